// File: rtl/nr_iter_ctrl.sv
// nr_iter_ctrl: sequences Jacobian, function and step units through Newton-Raphson iterations on a Q8.24 3-vector
module nr_iter_ctrl #(
  parameter int DW       = 32,
  parameter int FRAC     = 24,
  parameter int MAX_ITER = 16,
  parameter int TMO      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [DW-1:0] x0,
  input  logic signed [DW-1:0] y0,
  input  logic signed [DW-1:0] z0,
  input  logic        [DW-1:0] tol,
  output logic                 jac_en,
  input  logic                 jac_done,
  output logic                 fn_start,
  input  logic                 fn_done,
  output logic                 upd_start,
  input  logic                 upd_done,
  input  logic signed [DW-1:0] dx,
  input  logic signed [DW-1:0] dy,
  input  logic signed [DW-1:0] dz,
  output logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y,
  output logic signed [DW-1:0] z,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic        [1:0]    err,
  output logic        [7:0]    iter
);
  localparam int WW = $clog2(TMO + 1);
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  if (FRAC >= DW || MAX_ITER < 1 || MAX_ITER > 255 || TMO < 1) begin : g_bad_cfg
    $error("nr_iter_ctrl: invalid parameter set");
  end
  typedef enum logic [2:0] {IDLE, JAC, FN, UPD, CHK, DONE} state_e;
  state_e          state_q;
  logic [DW-1:0]   x_q, y_q, z_q, mx_q, my_q, mz_q;
  logic [7:0]      iter_q;
  logic [1:0]      err_q;
  logic [WW-1:0]   wd_q;
  logic            conv_q, busy_q, done_q, jac_en_q, fn_start_q, upd_start_q;
  logic            awaited;
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    return (d[DW] ^ d[DW-1]) ? (d[DW] ? SMIN : SMAX) : d[DW-1:0];
  endfunction
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] a);
    return !a[DW-1] ? a : (a == SMIN) ? SMAX : -a;
  endfunction
  // the completion input belonging to the unit currently being waited on
  always_comb awaited = state_q == JAC ? jac_done : state_q == FN ? fn_done : (state_q == UPD) & upd_done;
  // solve FSM: pulses are cleared every cycle and only raised on a state transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      mz_q        <= '0;
      iter_q      <= '0;
      err_q       <= '0;
      wd_q        <= '0;
      conv_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      jac_en_q    <= 1'b0;
      fn_start_q  <= 1'b0;
      upd_start_q <= 1'b0;
    end else begin
      jac_en_q    <= 1'b0;
      fn_start_q  <= 1'b0;
      upd_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          x_q      <= x0;
          y_q      <= y0;
          z_q      <= z0;
          iter_q   <= '0;
          err_q    <= '0;
          conv_q   <= 1'b0;
          wd_q     <= '0;
          busy_q   <= 1'b1;
          jac_en_q <= 1'b1;
          state_q  <= JAC;
        end
        JAC, FN, UPD:
          if (abort) begin
            err_q   <= 2'b11;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (awaited) begin
            wd_q        <= '0;
            fn_start_q  <= state_q == JAC;
            upd_start_q <= state_q == FN;
            state_q     <= state_q == JAC ? FN : state_q == FN ? UPD : CHK;
            if (state_q == UPD) begin
              x_q    <= sat_sub(x_q, dx);
              y_q    <= sat_sub(y_q, dy);
              z_q    <= sat_sub(z_q, dz);
              mx_q   <= mag(dx);
              my_q   <= mag(dy);
              mz_q   <= mag(dz);
              iter_q <= iter_q + 8'd1;
            end
          end else if (wd_q == WW'(TMO - 1)) begin
            err_q   <= 2'b10;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else wd_q <= wd_q + 1'b1;
        CHK:
          if (abort) begin
            err_q   <= 2'b11;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (mx_q <= tol && my_q <= tol && mz_q <= tol) begin
            conv_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (iter_q == 8'(MAX_ITER)) begin
            err_q   <= 2'b01;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            wd_q     <= '0;
            jac_en_q <= 1'b1;
            state_q  <= JAC;
          end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;
  assign iter      = iter_q;
  assign err       = err_q;
  assign converged = conv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign jac_en    = jac_en_q;
  assign fn_start  = fn_start_q;
  assign upd_start = upd_start_q;
endmodule

// File: tb/tb_nr_iter_ctrl.sv
// tb_nr_iter_ctrl: directed solves with a result scoreboard checked on every done pulse
module tb_nr_iter_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] x0 = '0, y0 = '0, z0 = '0, tol = '0, dx = '0, dy = '0, dz = '0;
  logic jac_done = 1'b0, fn_done = 1'b0, upd_done = 1'b0;
  logic jac_en, fn_start, upd_start, busy, done, converged;
  logic [31:0] x, y, z;
  logic [1:0] err;
  logic [7:0] iter;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] x, y, z;
    logic [7:0]  iter;
    logic [1:0]  err;
    logic        conv;
  } res_t;
  res_t q[$];
  res_t e;
  logic prev_done = 1'b0;

  nr_iter_ctrl #(.DW(32), .FRAC(24), .MAX_ITER(3), .TMO(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .z0(z0), .tol(tol),
    .jac_en(jac_en), .jac_done(jac_done), .fn_start(fn_start), .fn_done(fn_done),
    .upd_start(upd_start), .upd_done(upd_done), .dx(dx), .dy(dy), .dz(dz),
    .x(x), .y(y), .z(z), .busy(busy), .done(done), .converged(converged),
    .err(err), .iter(iter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic push(input logic [31:0] ex, ey, ez, input logic [7:0] it, input logic [1:0] er, input logic cv);
    res_t r;
    r.x = ex; r.y = ey; r.z = ez; r.iter = it; r.err = er; r.conv = cv;
    q.push_back(r);
  endtask

  task automatic launch(input logic [31:0] a, b, c, t);
    x0 = a; y0 = b; z0 = c; tol = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic await(input int sel, input string nm);
    for (int i = 0; i < 40; i++) begin
      if ((sel == 0) ? jac_en : (sel == 1) ? fn_start : upd_start) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_%s: no pulse within 40 cycles", nm);
  endtask

  task automatic pulse(input int sel);
    if (sel == 0) jac_done = 1'b1; else if (sel == 1) fn_done = 1'b1; else upd_done = 1'b1;
    @(posedge clk); #1;
    jac_done = 1'b0; fn_done = 1'b0; upd_done = 1'b0;
  endtask

  task automatic step(input logic [31:0] a, b, c);
    logic [31:0] xs;
    await(0, "jac");
    xs = x;
    pulse(0);
    await(1, "fn");
    pulse(1);
    await(2, "upd");
    chk("x_hold", x, xs);
    dx = a; dy = b; dz = c;
    pulse(2);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy still %b after 40 cycles", busy);
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = q.pop_front();
        chk("res_x", x, e.x);
        chk("res_y", y, e.y);
        chk("res_z", z, e.z);
        chk("res_iter", {24'd0, iter}, {24'd0, e.iter});
        chk("res_err", {30'd0, err}, {30'd0, e.err});
        chk("res_conv", {31'd0, converged}, {31'd0, e.conv});
      end
    end
    prev_done = rst_n & done;
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_iter", {24'd0, iter}, 0);
    chk("rst_err", {30'd0, err}, 0);
    chk("rst_conv", {31'd0, converged}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_jac_en", {31'd0, jac_en}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // two-step convergence
    push(32'h00EFF000, 32'h00EFF000, 32'h00EFF000, 8'd2, 2'b00, 1'b1);
    launch(32'h01000000, 32'h01000000, 32'h01000000, 32'h00010000);
    chk("busy_run", {31'd0, busy}, 1);
    step(32'h00100000, 32'h00100000, 32'h00100000);
    step(32'h00001000, 32'h00001000, 32'h00001000);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_x", x, 32'h00EFF000);
    chk("hold_conv", {31'd0, converged}, 1);
    chk("hold_busy", {31'd0, busy}, 0);
    // magnitude exactly equal to tol converges, negative step uses its magnitude
    push(32'hFFFF0000, 32'h00010000, 32'h0, 8'd1, 2'b00, 1'b1);
    launch(32'h0, 32'h0, 32'h0, 32'h00010000);
    step(32'h00010000, 32'hFFFF0000, 32'h0);
    wait_idle();
    // iteration limit
    push(32'hFE000000, 32'hFE000000, 32'hFE000000, 8'd3, 2'b01, 1'b0);
    launch(32'h01000000, 32'h01000000, 32'h01000000, 32'h00010000);
    repeat (3) step(32'h01000000, 32'h01000000, 32'h01000000);
    wait_idle();
    // saturation both ways, most-negative step never converges
    push(32'h7FFFFFFF, 32'h80000000, 32'h0, 8'd3, 2'b01, 1'b0);
    launch(32'h7F000000, 32'h80000000, 32'h0, 32'h00010000);
    chk("err_clr", {30'd0, err}, 0);
    repeat (3) step(32'h80000000, 32'h01000000, 32'h0);
    wait_idle();
    // watchdog in FN
    push(32'h00200000, 32'h00200000, 32'h00200000, 8'd0, 2'b10, 1'b0);
    launch(32'h00200000, 32'h00200000, 32'h00200000, 32'h00010000);
    await(0, "jac");
    pulse(0);
    await(1, "fn");
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (err == 2'b10) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycles", n, 8);
    wait_idle();
    // fn_done on the limit cycle wins over the watchdog
    push(32'h00300000, 32'h00300000, 32'h00300000, 8'd1, 2'b00, 1'b1);
    launch(32'h00300000, 32'h00300000, 32'h00300000, 32'h00010000);
    await(0, "jac");
    pulse(0);
    await(1, "fn");
    repeat (7) @(posedge clk);
    #1;
    pulse(1);
    chk("prec_err", {30'd0, err}, 0);
    await(2, "upd");
    dx = 0; dy = 0; dz = 0;
    pulse(2);
    wait_idle();
    // start while busy ignored, abort beats upd_done
    push(32'h00500000, 32'h00600000, 32'h00700000, 8'd0, 2'b11, 1'b0);
    launch(32'h00500000, 32'h00600000, 32'h00700000, 32'h00010000);
    await(0, "jac");
    x0 = 32'h11111111;
    start = 1'b1;
    pulse(0);
    start = 1'b0;
    await(1, "fn");
    pulse(1);
    await(2, "upd");
    dx = 32'h00100000; dy = 32'h00100000; dz = 32'h00100000;
    abort = 1'b1;
    pulse(2);
    abort = 1'b0;
    wait_idle();
    // asynchronous reset in FN
    launch(32'h00300000, 32'h00300000, 32'h00300000, 32'h00010000);
    await(0, "jac");
    pulse(0);
    await(1, "fn");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_z", z, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_fn_start", {31'd0, fn_start}, 0);
    chk("arst_upd_start", {31'd0, upd_start}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_idle", {31'd0, busy}, 0);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nr_iter_ctrl.md
NR_ITER_CTRL -- requirements
Module: nr_iter_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, data word width, signed fixed point Q8.24.
REQ-002 SHALL have parameter FRAC, default 24, fraction bits of every data word.
REQ-003 SHALL have parameter MAX_ITER, default 16, iteration limit (1..255).
REQ-004 SHALL have parameter TMO, default 255, per-stage watchdog limit in cycles.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  begin solve; sampled in IDLE only.
REQ-008 SHALL have port abort  in  1  terminate solve.
REQ-009 SHALL have ports x0, y0, z0  in  DW signed  initial guess.
REQ-010 SHALL have port tol  in  DW unsigned  convergence tolerance.
REQ-011 SHALL have port jac_en  out  1  one-cycle start pulse to the Jacobian-inverse unit.
REQ-012 SHALL have port jac_done  in  1  Jacobian-inverse unit complete.
REQ-013 SHALL have ports fn_start / fn_done  out / in  1  function-evaluation start pulse / complete.
REQ-014 SHALL have ports upd_start / upd_done  out / in  1  step-unit start pulse / complete.
REQ-015 SHALL have ports dx, dy, dz  in  DW signed  Newton step; valid in the upd_done cycle.
REQ-016 SHALL have ports x, y, z  out  DW signed  current estimate, registered.
REQ-017 SHALL have ports busy, done, converged  out  1  solve active / one-cycle completion pulse / result converged.
REQ-018 SHALL have ports err  out  2 (00 none, 01 iteration limit, 10 timeout, 11 abort) and iter  out  8  completed iterations.

Function
REQ-019 SHALL implement states IDLE, JAC, FN, UPD, CHK, DONE.
REQ-020 IDLE: start=1 SHALL load x,y,z<=x0,y0,z0; clear iter, err, converged; assert jac_en next cycle; enter JAC.
REQ-021 JAC: jac_done SHALL pulse fn_start next cycle and enter FN.
REQ-022 FN: fn_done SHALL pulse upd_start next cycle and enter UPD.
REQ-023 UPD: upd_done SHALL register x<=x-dx, y<=y-dy, z<=z-dz, iter<=iter+1, and capture |dx|,|dy|,|dz|; enter CHK.
REQ-024 Subtraction SHALL saturate to the signed DW range; no wrap-around.
REQ-025 CHK (exactly one cycle): all captured magnitudes <= tol -> converged=1, enter DONE; else iter==MAX_ITER -> err=01, enter DONE; else pulse jac_en, enter JAC.
REQ-026 Magnitude of the most-negative value SHALL be 2^(DW-1)-1.
REQ-027 DONE SHALL assert done for one cycle, then enter IDLE.
REQ-028 x, y, z SHALL stay constant from the jac_en pulse until the upd_done edge.
REQ-029 Watchdog SHALL clear on entry to JAC/FN/UPD and count each cycle without the awaited done; reaching TMO sets err=10 and enters DONE.
REQ-030 A done in the same cycle the watchdog reaches TMO SHALL take precedence.
REQ-031 abort in any state other than IDLE/DONE SHALL set err=11, suppress pending start pulses, and enter DONE; abort beats a simultaneous done input.
REQ-032 start while busy, and done inputs outside their own state, SHALL be ignored.
REQ-033 busy SHALL be 1 in every state except IDLE; converged, err, iter, x, y, z SHALL hold after DONE until the next accepted start.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE; clear x, y, z, iter, err, converged, watchdog; drive busy, done, jac_en, fn_start, upd_start to 0.
REQ-035 Reset asserted mid-solve SHALL abandon the iteration without issuing done.

Verification
REQ-036 Converge: x0=y0=z0=0x01000000, tol=0x00010000, steps 0x00100000 then 0x00001000 -> iter=2, converged=1, err=00, x=0x00EFF000.
REQ-037 Limit: MAX_ITER=3, dx=0x01000000 each iteration -> done after iter=3, err=01, converged=0.
REQ-038 Timeout: TMO=8, fn_done never asserted -> err=10 exactly 8 cycles after FN entry, done pulses once.
REQ-039 Saturation: x0=0x7F000000, dx=0x80000000 -> x=0x7FFFFFFF; magnitude 0x7FFFFFFF, no convergence.
REQ-040 Abort and reset: abort coincident with upd_done -> err=11, x unchanged; rst_n low in FN -> all outputs 0 asynchronously, no done pulse.
